// File: rtl/vm1_prefetch.sv
// Instruction prefetch queue for the 1801VM1 core.
// Fetches sequential even-address words into a small circular buffer and
// presents the head word with its post-fetch PC to the decoder. A PC load
// flushes the queue. A bus transfer that is already in flight cannot be
// aborted, so it is drained and its data is dropped.
module vm1_prefetch #(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = 16'o000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   output logic        bus_req,
   output logic [15:0] bus_addr,
   input  logic        bus_ack,
   input  logic        bus_err,
   input  logic [15:0] bus_rdata,
   input  logic        pc_load,
   input  logic [15:0] pc_new,
   input  logic        q_take,
   output logic        q_valid,
   output logic [15:0] q_word,
   output logic [15:0] q_pc,
   output logic        fetch_err
);

   localparam int PW = (DEPTH > 2) ? 2 : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
   localparam logic [PW-1:0] PONE_C  = PW'(1);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state_reg, state_next;
   logic            bus_req_reg, bus_req_next;
   logic [15:0]     bus_addr_reg, bus_addr_next;
   logic [15:0]     fa_reg, fa_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [PW-1:0]   head_reg, head_next;
   logic [PW-1:0]   tail_reg, tail_next;
   logic            fetch_err_reg, fetch_err_next;
   logic [CW-1:0]   count_pop;
   logic            push, pop;
   logic [15:0]     fa_inc;

   logic [15:0] word_mem [DEPTH];
   logic [15:0] pc_mem   [DEPTH];

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PONE_C;
   endfunction

   // Next fetch address; the 16-bit add wraps 177776 around to 0.
   assign fa_inc = fa_reg + 16'd2;

   // Next-state logic: fetch sequencing, queue bookkeeping and redirect.
   always_comb begin
      state_next     = state_reg;
      bus_req_next   = bus_req_reg;
      bus_addr_next  = bus_addr_reg;
      fa_next        = fa_reg;
      count_next     = count_reg;
      head_next      = head_reg;
      tail_next      = tail_reg;
      fetch_err_next = fetch_err_reg;
      push           = 1'b0;
      pop            = 1'b0;
      count_pop      = count_reg;
      if (ce) begin
         pop = q_take && (count_reg != '0) && !pc_load;
         if (pop) count_pop = count_reg - ONE_C;
         unique case (state_reg)
            IDLE: begin
               if ((count_reg < DEPTH_C) && !fetch_err_reg && !pc_load) begin
                  state_next    = REQ;
                  bus_req_next  = 1'b1;
                  bus_addr_next = fa_reg;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  bus_req_next = 1'b0;
                  state_next   = IDLE;
                  if (!pc_load) begin
                     if (bus_err) begin
                        fetch_err_next = 1'b1;
                     end else begin
                        push    = 1'b1;
                        fa_next = fa_inc;
                        // Chain straight into the next fetch while room remains.
                        if ((count_pop + ONE_C) < DEPTH_C) begin
                           state_next    = REQ;
                           bus_req_next  = 1'b1;
                           bus_addr_next = fa_inc;
                        end
                     end
                  end
               end else if (pc_load) begin
                  state_next = DISCARD;
               end
            end
            DISCARD: begin
               if (bus_ack) begin
                  bus_req_next = 1'b0;
                  state_next   = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
         count_next = push ? (count_pop + ONE_C) : count_pop;
         if (pop)  head_next = ptr_inc(head_reg);
         if (push) tail_next = ptr_inc(tail_reg);
         if (pc_load) begin
            count_next     = '0;
            head_next      = '0;
            tail_next      = '0;
            fa_next        = {pc_new[15:1], 1'b0};
            fetch_err_next = pc_new[0];
         end
      end
   end

   // Control registers with asynchronous reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         bus_req_reg   <= 1'b0;
         bus_addr_reg  <= RESET_PC;
         fa_reg        <= RESET_PC;
         count_reg     <= '0;
         head_reg      <= '0;
         tail_reg      <= '0;
         fetch_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bus_req_reg   <= bus_req_next;
         bus_addr_reg  <= bus_addr_next;
         fa_reg        <= fa_next;
         count_reg     <= count_next;
         head_reg      <= head_next;
         tail_reg      <= tail_next;
         fetch_err_reg <= fetch_err_next;
      end
   end

   // Queue storage: word and its post-fetch PC, written at the tail.
   always_ff @(posedge clk) begin
      if (push) begin
         word_mem[tail_reg] <= bus_rdata;
         pc_mem[tail_reg]   <= fa_inc;
      end
   end

   assign bus_req   = bus_req_reg;
   assign bus_addr  = bus_addr_reg;
   assign fetch_err = fetch_err_reg;
   assign q_valid   = (count_reg != '0);
   // Head is forced to zero when empty so stale storage never leaks out.
   assign q_word    = q_valid ? word_mem[head_reg] : 16'h0000;
   assign q_pc      = q_valid ? pc_mem[head_reg]   : 16'h0000;

endmodule

// File: tb/tb_vm1_prefetch.sv
// Self-checking bench for vm1_prefetch: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_vm1_prefetch;

   localparam int          DEPTH    = 2;
   localparam logic [15:0] RESET_PC = 16'o000000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce;
   logic        bus_req;
   logic [15:0] bus_addr;
   logic        bus_ack;
   logic        bus_err;
   logic [15:0] bus_rdata;
   logic        pc_load;
   logic [15:0] pc_new;
   logic        q_take;
   logic        q_valid;
   logic [15:0] q_word;
   logic [15:0] q_pc;
   logic        fetch_err;

   vm1_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .bus_req   (bus_req),
      .bus_addr  (bus_addr),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .bus_rdata (bus_rdata),
      .pc_load   (pc_load),
      .pc_new    (pc_new),
      .q_take    (q_take),
      .q_valid   (q_valid),
      .q_word    (q_word),
      .q_pc      (q_pc),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: the queue contents, the fetch pointer, the sticky
   // fault, and the outstanding bus transfer (with a flag for "drop it").
   typedef struct {
      logic [15:0] w;
      logic [15:0] pc;
   } ent_t;
   ent_t        mq[$];
   logic [15:0] m_fa;
   logic [15:0] m_addr;
   bit          m_req;
   bit          m_disc;
   bit          m_ferr;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (a == 16'o000000) return 16'o012700;
      if (a == 16'o000002) return 16'o000123;
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%o expected=%o at t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fa   = RESET_PC;
      m_addr = RESET_PC;
      m_req  = 1'b0;
      m_disc = 1'b0;
      m_ferr = 1'b0;
   endtask

   task automatic check_outputs();
      logic [15:0] ew, ep;
      ew = (mq.size() != 0) ? mq[0].w  : 16'h0000;
      ep = (mq.size() != 0) ? mq[0].pc : 16'h0000;
      check_val("bus_req",   {15'd0, bus_req},   {15'd0, m_req});
      check_val("bus_addr",  bus_addr,           m_addr);
      check_val("q_valid",   {15'd0, q_valid},   {15'd0, (mq.size() != 0)});
      check_val("q_word",    q_word,             ew);
      check_val("q_pc",      q_pc,               ep);
      check_val("fetch_err", {15'd0, fetch_err}, {15'd0, m_ferr});
   endtask

   // One clock: check at the falling edge, drive inputs, advance the model.
   task automatic step(input bit i_ce, input bit i_ack, input bit i_err,
                       input logic [15:0] i_rdata, input bit i_load,
                       input logic [15:0] i_new, input bit i_take);
      bit take_eff, was_req, done, normal, ferr_before;
      int size_before;
      check_outputs();
      ce        = i_ce;
      bus_ack   = i_ack;
      bus_err   = i_err;
      bus_rdata = i_rdata;
      pc_load   = i_load;
      pc_new    = i_new;
      q_take    = i_take;
      if (i_ce) begin
         take_eff    = i_take && (mq.size() != 0) && !i_load;
         size_before = mq.size();
         was_req     = m_req;
         ferr_before = m_ferr;
         done        = m_req && i_ack;
         normal      = done && !m_disc && !i_load && !i_err;
         if (take_eff) void'(mq.pop_front());
         if (normal) begin
            mq.push_back('{w: i_rdata, pc: m_addr + 16'd2});
            m_fa = m_addr + 16'd2;
            $display("fetch addr=%06o data=%06o pc=%06o depth=%0d", m_addr, i_rdata, m_fa, mq.size());
         end
         if (done && !m_disc && !i_load && i_err) m_ferr = 1'b1;
         if (done) begin
            m_req  = 1'b0;
            m_disc = 1'b0;
         end
         if (normal && mq.size() < DEPTH) begin
            m_req  = 1'b1;
            m_addr = m_fa;
         end else if (!was_req && !i_load && size_before < DEPTH && !ferr_before) begin
            m_req  = 1'b1;
            m_addr = m_fa;
         end
         if (i_load) begin
            mq.delete();
            m_fa   = {i_new[15:1], 1'b0};
            m_ferr = i_new[0];
            if (was_req && !i_ack) m_disc = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Memory always answering at once; optional take and ce toggling.
   task automatic run_fetch(input int n, input bit take, input bit ce_toggle);
      for (int i = 0; i < n; i++) begin
         step(ce_toggle ? i[0] : 1'b1, m_req, 1'b0, mem_word(m_addr), 1'b0, 16'h0, take);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
   endtask

   task automatic load(input logic [15:0] a);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1, a, 1'b0);
   endtask

   initial begin
      reset_n   = 1'b0;
      ce        = 1'b1;
      bus_ack   = 1'b0;
      bus_err   = 1'b0;
      bus_rdata = 16'h0;
      pc_load   = 1'b0;
      pc_new    = 16'h0;
      q_take    = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs();
      reset_n = 1'b1;

      // Fill from RESET_PC, then stream with takes, then again with ce toggling.
      run_fetch(6, 1'b0, 1'b0);
      run_fetch(8, 1'b1, 1'b0);
      run_fetch(12, 1'b1, 1'b1);

      // Redirect while a fetch is outstanding; the late data must be dropped.
      load(16'o000010);
      idle(1);
      load(16'o001000);
      idle(2);
      step(1'b1, 1'b1, 1'b0, 16'o177777, 1'b0, 16'h0, 1'b0);
      run_fetch(5, 1'b0, 1'b0);

      // Bus error sets the sticky fault; a new PC load clears it.
      load(16'o000200);
      idle(1);
      step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h0, 1'b0);
      idle(3);
      load(16'o000300);
      run_fetch(4, 1'b0, 1'b0);

      // Odd target faults without fetching; then address wrap at 177776.
      load(16'o000401);
      run_fetch(3, 1'b0, 1'b0);
      load(16'o177776);
      run_fetch(5, 1'b0, 1'b0);
      run_fetch(4, 1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         bit          r_ce, r_ack, r_err, r_load, r_take;
         logic [15:0] r_new, r_data;
         int          sel;
         r_ce   = ($urandom_range(0, 99) < 85);
         r_ack  = m_req && ($urandom_range(0, 99) < 60);
         r_err  = r_ack && ($urandom_range(0, 99) < 4);
         r_load = ($urandom_range(0, 99) < 5);
         r_take = ($urandom_range(0, 99) < 50);
         sel    = $urandom_range(0, 3);
         r_new  = 16'($urandom);
         if (sel == 0)      r_new[0] = 1'b1;
         else if (sel == 1) r_new = 16'o177772 + 16'(2 * $urandom_range(0, 2));
         else               r_new[0] = 1'b0;
         r_data = (r_err || m_disc) ? 16'($urandom) : mem_word(m_addr);
         step(r_ce, r_ack, r_err, r_data, r_load, r_new, r_take);
      end

      // Asynchronous reset in the middle of a transfer drops bus_req at once.
      load(16'o002000);
      idle(1);
      check_val("req_before_reset", {15'd0, bus_req}, 16'd1);
      #2 reset_n = 1'b0;
      #1;
      check_val("async_req", {15'd0, bus_req}, 16'd0);
      check_val("async_addr", bus_addr, RESET_PC);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      run_fetch(6, 1'b0, 1'b0);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vm1_prefetch.md
Name: vm1_prefetch

Overview:
- Instruction prefetch queue for the 1801VM1 soft CPU. It sits directly upstream of the instruction decoder.
- Fetches 16-bit words from the CPU bus at sequential even addresses and buffers up to DEPTH of them.
- Presents the head word, with its post-fetch PC, to the decoder (head word drives idc_opc) and the execution sequencer.
- Supports flush/redirect on PC load (branches, JMP, JSR, RTS, RTI, traps) and reports bus-error and odd-address fetch faults.

Parameters:
- DEPTH, 2: queue capacity in words (2..4); also covers opcode + one extension word.
- RESET_PC, 16'o000000: fetch address after reset.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; all registers update only when ce=1
- bus_req  out  1  fetch read request
- bus_addr  out  16  fetch address, always even
- bus_ack  in  1  read completes this cycle
- bus_err  in  1  qualifies bus_ack: bus timeout/error
- bus_rdata  in  16  read data, valid with bus_ack
- pc_load  in  1  redirect: flush queue, restart at pc_new
- pc_new  in  16  new fetch address
- q_take  in  1  consume head word
- q_valid  out  1  head word present
- q_word  out  16  head word (to decoder opcode input / extension word)
- q_pc  out  16  address of head word + 2, i.e. PC after consuming it
- fetch_err  out  1  sticky fault: bus error or odd pc_new

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: bus_req=0, bus_addr=RESET_PC, q_valid=0, q_word=0, q_pc=0, fetch_err=0.
  - Internal: fetch address fa=RESET_PC, count=0, state IDLE.
  - Reset mid-transfer abandons the transfer; bus_req drops immediately.
- Queue:
  - Circular buffer of DEPTH entries {word, pc}, with head/tail pointers and a count of 0..DEPTH.
  - q_valid = (count != 0). q_word and q_pc come from the head entry combinationally off registered storage.
- FSM states: IDLE, REQ, DISCARD.
- IDLE: if count < DEPTH and fetch_err=0 and pc_load=0, go to REQ, set bus_req=1, bus_addr=fa (registered, one cycle after space appears).
- REQ:
  - bus_req and bus_addr are held stable until bus_ack.
  - On bus_ack with bus_err=0: push {bus_rdata, fa+2}, set fa=fa+2 (16-bit wrap; 16'o177776 wraps to 0), clear bus_req. If space remains after this push and any simultaneous take, go directly back to REQ with the new address next cycle. Otherwise go to IDLE.
  - On bus_ack with bus_err=1: no push, set fetch_err=1, clear bus_req, go to IDLE.
- DISCARD:
  - Entered when pc_load occurs while in REQ without ack in the same cycle. The bus transfer cannot be aborted, so bus_req and the old bus_addr are held until bus_ack.
  - Data and bus_err at that ack are dropped. Then go to IDLE.
  - Further pc_load while in DISCARD only updates fa.
- pc_load (any state):
  - Same cycle: count=0, head=tail=0, q_valid=0 next cycle.
  - fa = pc_new with bit0 cleared; fetch_err cleared.
  - If pc_new[0]=1: fetch_err=1 instead and no fetch until the next pc_load.
  - pc_load wins over a simultaneous q_take (take ignored) and over a simultaneous bus_ack (data dropped; fa still takes pc_new).
- q_take:
  - Pops the head when q_valid=1. q_take with q_valid=0 is ignored.
  - Take and push in the same cycle leave count unchanged (push into the full queue is permitted when a take happens in the same cycle).
- Latency, empty queue: bus_ack at cycle N gives q_valid=1 at N+1.
- ce=0 freezes all state. bus_ack, q_take and pc_load are ignored when ce=0.
- fetch_err does not flush the queue. Already-buffered words stay consumable; the core raises the trap when it needs a word and finds q_valid=0 with fetch_err=1.

Test Plan:
1. Reset release, RESET_PC=0, memory returns 012700,000123 with 1-cycle ack → bus_addr 0 then 2. q_word=012700 with q_pc=2, then 000123 with q_pc=4. bus_req drops with queue full (DEPTH=2).
2. Queue full, q_take every cycle for 6 cycles with ack always high → addresses 4,6,8… issued back-to-back. No word lost or duplicated; count never exceeds DEPTH.
3. pc_load pc_new=001000 while REQ to 000010 pending, ack 3 cycles later with data 177777 → 177777 never appears. q_valid=0 until next ack. Next bus_addr=001000.
4. bus_ack with bus_err=1 at address 000200 → fetch_err=1, no push, bus_req stays 0. Then pc_load 000300 → fetch_err=0, fetch at 000300.
5. pc_load pc_new=000401 → fetch_err=1, no bus_req. fa=177776 fetch → pushed q_pc=000000, next bus_addr=000000 (wrap).
6. ce toggled 0/1 every cycle during scenario 2 → identical word/pc sequence; no state change on ce=0 cycles.
